// File: rtl/delay_sensor_pkg.sv
// Shared types and helpers for the delay-chain sensor: FSM states, depth
// width and the polarity-correction mask for the inverting chain.
package delay_sensor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_SYNC    = 3'd3,
    ST_ENCODE  = 3'd4,
    ST_SETTLE  = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  // Width needed to hold a depth in 0..chain_len.
  function automatic int dw_f(input int chain_len);
    return $clog2(chain_len + 1);
  endfunction

  // Bit k set when stage k is even, i.e. when its settled output is the
  // inverse of the chain input. Callers truncate to their chain length.
  function automatic logic [255:0] pol_mask_f(input int chain_len);
    logic [255:0] mask;
    mask = '0;
    for (int k = 0; k < 256; k++) begin
      if ((k < chain_len) && ((k % 2) == 0)) begin
        mask[k] = 1'b1;
      end else begin
        mask[k] = 1'b0;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/delay_tap_chain.sv
// Inverting delay line of CHAIN_LEN single-path stages. Every stage output
// is kept through synthesis and exposed as one bit of the tap bus.
module delay_tap_chain #(
  parameter int CHAIN_LEN = 64
) (
  input  logic                 chain_in_i,
  output logic [CHAIN_LEN-1:0] tap_o
);

  for (genvar k = 0; k < CHAIN_LEN; k++) begin : g_stage
    (* keep *) logic stage_w;
    logic            prev_w;

    if (k == 0) begin : g_head
      assign prev_w = chain_in_i;
    end else begin : g_link
      assign prev_w = g_stage[k-1].stage_w;
    end

    assign stage_w  = ~prev_w;
    assign tap_o[k] = stage_w;
  end

endmodule

// File: rtl/delay_chain_sensor.sv
// Delay-chain sensor: launches alternating transitions into the tap chain,
// double-flops the taps, encodes the propagation depth and accumulates
// sum/min/max over 2^SAMPLES_LOG2 samples, with a sticky bubble flag.
module delay_chain_sensor
  import delay_sensor_pkg::*;
#(
  parameter int CHAIN_LEN     = 64,
  parameter int SAMPLES_LOG2  = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   start_i,
  output logic                                   busy_o,
  input  logic                                   tap_override_en_i,
  input  logic [CHAIN_LEN-1:0]                   tap_override_i,
  output logic                                   result_valid_o,
  input  logic                                   result_ready_i,
  output logic [dw_f(CHAIN_LEN)+SAMPLES_LOG2-1:0] depth_sum_o,
  output logic [dw_f(CHAIN_LEN)-1:0]             depth_min_o,
  output logic [dw_f(CHAIN_LEN)-1:0]             depth_max_o,
  output logic [dw_f(CHAIN_LEN)-1:0]             last_depth_o,
  output logic                                   bubble_err_o
);

  localparam int DW  = dw_f(CHAIN_LEN);
  localparam int SW  = DW + SAMPLES_LOG2;
  localparam int CW  = (SAMPLES_LOG2 > 0) ? SAMPLES_LOG2 : 1;
  localparam int SCW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CHAIN_LEN-1:0] POL_MASK    = CHAIN_LEN'(pol_mask_f(CHAIN_LEN));
  localparam logic [CW-1:0]        SAMPLE_LAST = CW'((1 << SAMPLES_LOG2) - 1);
  localparam logic [SCW-1:0]       SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

  state_e                 state_q;
  logic                   launch_q;
  logic [CHAIN_LEN-1:0]   tap1_q;
  logic [CHAIN_LEN-1:0]   tap2_q;
  logic [CW-1:0]          sample_cnt_q;
  logic [SCW-1:0]         settle_cnt_q;
  logic [SW-1:0]          sum_q;
  logic [DW-1:0]          min_q;
  logic [DW-1:0]          max_q;
  logic [DW-1:0]          last_q;
  logic                   bubble_q;
  logic                   busy_q;
  logic                   valid_q;

  logic [CHAIN_LEN-1:0]   tap_s;
  logic [CHAIN_LEN-1:0]   reached_s;
  logic [DW-1:0]          depth_s;
  logic                   bubble_s;
  logic                   gap_s;
  logic [SW-1:0]          sum_d;
  logic [DW-1:0]          min_d;
  logic [DW-1:0]          max_d;

  delay_tap_chain #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_chain (
    .chain_in_i (launch_q),
    .tap_o      (tap_s)
  );

  // Reached flags: override bus, or polarity-corrected taps matching the launch value.
  always_comb begin
    reached_s = '0;
    if (tap_override_en_i) begin
      reached_s = tap_override_i;
    end else begin
      reached_s = ~(tap2_q ^ POL_MASK ^ {CHAIN_LEN{launch_q}});
    end
  end

  // Leading-ones depth from bit 0, and bubble when a reached bit follows a gap.
  always_comb begin
    depth_s  = '0;
    bubble_s = 1'b0;
    gap_s    = 1'b0;
    for (int k = 0; k < CHAIN_LEN; k++) begin
      if (!reached_s[k]) begin
        gap_s = 1'b1;
      end else if (gap_s) begin
        bubble_s = 1'b1;
      end else begin
        depth_s = depth_s + DW'(1);
      end
    end
  end

  // Next accumulator values; min/max ties keep the stored value.
  always_comb begin
    sum_d = sum_q + SW'(depth_s);
    min_d = min_q;
    max_d = max_q;
    if (depth_s < min_q) begin
      min_d = depth_s;
    end else begin
      min_d = min_q;
    end
    if (depth_s > max_q) begin
      max_d = depth_s;
    end else begin
      max_d = max_q;
    end
  end

  // Measurement FSM with launch, capture/sync flops, accumulators and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      launch_q     <= 1'b0;
      tap1_q       <= '0;
      tap2_q       <= '0;
      sample_cnt_q <= '0;
      settle_cnt_q <= '0;
      sum_q        <= '0;
      min_q        <= '1;
      max_q        <= '0;
      last_q       <= '0;
      bubble_q     <= 1'b0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q      <= ST_LAUNCH;
            busy_q       <= 1'b1;
            sum_q        <= '0;
            min_q        <= '1;
            max_q        <= '0;
            bubble_q     <= 1'b0;
            sample_cnt_q <= '0;
          end
        end
        ST_LAUNCH: begin
          launch_q <= ~launch_q;
          state_q  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          tap1_q  <= tap_s;
          state_q <= ST_SYNC;
        end
        ST_SYNC: begin
          tap2_q  <= tap1_q;
          state_q <= ST_ENCODE;
        end
        ST_ENCODE: begin
          sum_q        <= sum_d;
          min_q        <= min_d;
          max_q        <= max_d;
          last_q       <= depth_s;
          bubble_q     <= bubble_q | bubble_s;
          settle_cnt_q <= '0;
          state_q      <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            if (sample_cnt_q == SAMPLE_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              valid_q <= 1'b1;
            end else begin
              sample_cnt_q <= sample_cnt_q + CW'(1);
              state_q      <= ST_LAUNCH;
            end
          end else begin
            settle_cnt_q <= settle_cnt_q + SCW'(1);
          end
        end
        ST_DONE: begin
          if (result_ready_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign result_valid_o = valid_q;
  assign depth_sum_o    = sum_q;
  assign depth_min_o    = min_q;
  assign depth_max_o    = max_q;
  assign last_depth_o   = last_q;
  assign bubble_err_o   = bubble_q;

endmodule

// File: tb/tb_delay_chain_sensor.sv
// Self-checking bench for delay_chain_sensor (CHAIN_LEN=8, 4 samples,
// SETTLE_CYCLES=4) against a behavioural model of the depth rules.
module tb_delay_chain_sensor;

  localparam int CL = 8;
  localparam int SL = 2;
  localparam int SC = 4;
  localparam int P  = 4 + SC;
  localparam int NS = 1 << SL;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       busy;
  logic       ov_en = 1'b0;
  logic [7:0] ov = 8'h00;
  logic       valid;
  logic       ready = 1'b0;
  logic [5:0] dsum;
  logic [3:0] dmin;
  logic [3:0] dmax;
  logic [3:0] dlast;
  logic       bubble;

  int tests = 0;
  int fails = 0;
  int n = 0;

  // model state for the run in flight
  int m_sum, m_min, m_max, m_last, m_bub;

  delay_chain_sensor #(
    .CHAIN_LEN     (CL),
    .SAMPLES_LOG2  (SL),
    .SETTLE_CYCLES (SC)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .busy_o            (busy),
    .tap_override_en_i (ov_en),
    .tap_override_i    (ov),
    .result_valid_o    (valid),
    .result_ready_i    (ready),
    .depth_sum_o       (dsum),
    .depth_min_o       (dmin),
    .depth_max_o       (dmax),
    .last_depth_o      (dlast),
    .bubble_err_o      (bubble)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    n++;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int lead_ones(input logic [7:0] v);
    int d = 0;
    while (d < CL && v[d] == 1'b1) d++;
    return d;
  endfunction

  task automatic check_result(input string tag);
    check({tag, "_valid"}, int'(valid), 1);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_sum"},   int'(dsum), m_sum);
    check({tag, "_min"},   int'(dmin), m_min);
    check({tag, "_max"},   int'(dmax), m_max);
    check({tag, "_last"},  int'(dlast), m_last);
    check({tag, "_bub"},   int'(bubble), m_bub);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},  int'(busy), 0);
    check({tag, "_valid"}, int'(valid), 0);
    check({tag, "_bub"},   int'(bubble), 0);
    check({tag, "_sum"},   int'(dsum), 0);
    check({tag, "_min"},   int'(dmin), 15);
    check({tag, "_max"},   int'(dmax), 0);
    check({tag, "_last"},  int'(dlast), 0);
  endtask

  // One full measurement; leaves the sensor in DONE with ready low.
  task automatic do_run(input string tag, input logic use_ov,
                        input logic [7:0] v0, input logic [7:0] v1,
                        input logic [7:0] v2, input logic [7:0] v3);
    logic [7:0] vals [4];
    int d;
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3;
    m_sum = 0; m_min = 15; m_max = 0; m_bub = 0;
    ov_en = use_ov;
    ov    = vals[0];
    start = 1'b1;
    n     = 0;
    tick();
    start = 1'b0;
    check({tag, "_busy_rise"}, int'(busy), 1);
    for (int j = 0; j < NS; j++) begin
      ov = vals[j];
      while (n < 5 + j * P) tick();
      if (use_ov) begin
        d = lead_ones(vals[j]);
        if ((vals[j] >> d) != 8'h00) m_bub = 1;
      end else begin
        d = CL;
      end
      m_sum  = m_sum + d;
      m_min  = (d < m_min) ? d : m_min;
      m_max  = (d > m_max) ? d : m_max;
      m_last = d;
      check({tag, "_sample_depth"}, int'(dlast), d);
    end
    while (!valid && n < 200) tick();
    check({tag, "_latency"}, n, NS * P + 1);
    check_result(tag);
  endtask

  task automatic accept(input string tag);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check({tag, "_acc_valid"}, int'(valid), 0);
    check({tag, "_acc_busy"},  int'(busy), 0);
  endtask

  initial begin
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;

    // ready without a result is ignored
    ready = 1'b1;
    tick();
    tick();
    ready = 1'b0;
    check("ready_idle_valid", int'(valid), 0);

    do_run("plan", 1'b1, 8'h07, 8'h0F, 8'h03, 8'h1F);
    accept("plan");
    do_run("bubble", 1'b1, 8'h0B, 8'h0B, 8'h0B, 8'h0B);
    accept("bubble");
    do_run("all", 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    accept("all");
    do_run("none", 1'b1, 8'h00, 8'h00, 8'h00, 8'h00);
    accept("none");
    do_run("live", 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    accept("live");
    for (int r = 0; r < 6; r++) begin
      do_run("rand", 1'b1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      accept("rand");
    end

    // back-pressure in DONE with stray start pulses
    do_run("bp", 1'b1, 8'h01, 8'h3F, 8'h07, 8'h0D);
    for (int c = 0; c < 10; c++) begin
      start = c[0];
      ov    = 8'($urandom);
      tick();
      check_result("bp_hold");
    end
    start = 1'b0;
    accept("bp");

    // reset during the third sample's settle phase
    ov_en = 1'b1;
    ov    = 8'h0F;
    start = 1'b1;
    n     = 0;
    tick();
    start = 1'b0;
    while (n < 5 + 2 * P + 1) tick();
    check("abort_busy_pre", int'(busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset("abort");
    do_run("fresh", 1'b1, 8'h01, 8'h03, 8'h01, 8'h00);
    accept("fresh");

    // start held high: one run per IDLE visit
    ov_en = 1'b1;
    ov    = 8'h03;
    start = 1'b1;
    n     = 0;
    tick();
    check("held_busy", int'(busy), 1);
    while (!valid && n < 200) tick();
    check("held_latency", n, NS * P + 1);
    tick();
    tick();
    check("held_done_stable", int'(valid), 1);
    check("held_done_busy", int'(busy), 0);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("held_idle_busy", int'(busy), 0);
    check("held_idle_valid", int'(valid), 0);
    tick();
    check("held_restart_busy", int'(busy), 1);
    start = 1'b0;
    n = 1;
    while (!valid && n < 200) tick();
    check("held2_latency", n, NS * P + 1);
    check("held2_sum", int'(dsum), 8);
    accept("held2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
